// File: rtl/serial_det_arb.sv
// Round-robin arbiter sharing one bit-serial pattern detector between two requesters.
// A granted word is shifted MSB-first through the detector; overlapping matches are counted.
module serial_det_arb #(
  parameter int                DW   = 8,
  parameter int                PLEN = 3,
  parameter logic [PLEN-1:0]   PAT  = 3'b011,
  parameter int                CW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  output logic          ack0,
  output logic          ack1,
  output logic          busy,
  output logic          bit_out,
  output logic          z,
  output logic          done,
  output logic          done_id,
  output logic [CW-1:0] match_cnt
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam int FW = $clog2(PLEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     shreg_q, shreg_d;
  logic [PLEN-2:0]   hist_q, hist_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              z_q, z_d;
  logic              cur_id_q, cur_id_d;
  logic              done_id_q, done_id_d;
  logic              last_id_q, last_id_d;
  logic              grant_id;
  logic              match;
  logic [PLEN-1:0]   window;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      bcnt_q    <= '0;
      cnt_q     <= '0;
      z_q       <= 1'b0;
      cur_id_q  <= 1'b0;
      done_id_q <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      bcnt_q    <= bcnt_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
      cur_id_q  <= cur_id_d;
      done_id_q <= done_id_d;
      last_id_q <= last_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    bcnt_d    = bcnt_q;
    cnt_d     = cnt_q;
    z_d       = 1'b0;
    cur_id_d  = cur_id_q;
    done_id_d = done_id_q;
    last_id_d = last_id_q;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = 1'b0;
    bit_out   = 1'b0;
    done      = 1'b0;
    match     = 1'b0;
    // On a tie the requester not served last wins; otherwise whoever is asking.
    grant_id  = (req0 && req1) ? ~last_id_q : req1;
    window    = {hist_q, shreg_q[DW-1]};

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          shreg_d   = grant_id ? data1 : data0;
          cur_id_d  = grant_id;
          done_id_d = grant_id;
          cnt_d     = '0;
          hist_d    = '0;
          fill_d    = '0;
          bcnt_d    = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        bit_out = shreg_q[DW-1];
        match   = (fill_q >= FW'(PLEN - 1)) && (window == PAT);
        shreg_d = {shreg_q[DW-2:0], 1'b0};
        hist_d  = window[PLEN-2:0];
        if (fill_q != FW'(PLEN)) fill_d = fill_q + 1'b1;
        if (match) begin
          cnt_d = cnt_q + 1'b1;
          z_d   = 1'b1;
        end
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BW'(DW - 1)) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        ack0      = ~cur_id_q;
        ack1      = cur_id_q;
        last_id_d = cur_id_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign z         = z_q;
  assign done_id   = done_id_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_serial_det_arb.sv
// Scoreboard bench for serial_det_arb: drivers push expected transactions,
// a negedge monitor pops and compares each completion.
module tb_serial_det_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       ack0, ack1, busy, bit_out, z, done, done_id;
  logic [3:0] match_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic       id;
    logic [7:0] bits;
    logic [3:0] cnt;
    logic [8:0] zm;
  } exp_t;

  exp_t sbq[$];
  int   done_cyc[$];

  serial_det_arb #(.DW(8), .PLEN(3), .PAT(3'b011), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .busy(busy), .bit_out(bit_out),
    .z(z), .done(done), .done_id(done_id), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [7:0] bits, input logic [3:0] cnt, input logic [8:0] zm);
    exp_t e;
    e.id = id; e.bits = bits; e.cnt = cnt; e.zm = zm;
    sbq.push_back(e);
  endtask

  // Bounded wait for the requester's ack, then drop req on the edge that sees it.
  task automatic wait_ack(input logic id);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (id ? ack1 : ack0) seen = 1;
    end
    if (!seen) chk("ack_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (id) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic do_word(input logic id, input logic [7:0] d, input logic [3:0] cnt, input logic [8:0] zm);
    push(id, d, cnt, zm);
    if (id) begin req1 = 1'b1; data1 = d; end
    else    begin req0 = 1'b1; data0 = d; end
    wait_ack(id);
  endtask

  // Monitor: collects bit_out/z across a transaction and checks on done.
  initial begin : monitor
    logic [7:0] bits;
    logic [8:0] zv;
    int         ncyc;
    exp_t       e;
    bits = '0; zv = '0; ncyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bits = '0; zv = '0; ncyc = 0;
      end else begin
        if (ack0 || ack1 || done) chk("ack_done_align", {31'd0, ack0 | ack1}, {31'd0, done});
        if (busy && !done) begin
          bits = {bits[6:0], bit_out};
          zv   = {zv[7:0], z};
          ncyc++;
        end else if (done) begin
          zv = {zv[7:0], z};
          ncyc++;
          done_cyc.push_back(cyc);
          if (sbq.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("done_id",   done_id, e.id);
            chk("ack_lines", {ack1, ack0}, e.id ? 2'b10 : 2'b01);
            chk("match_cnt", match_cnt, e.cnt);
            chk("bit_seq",   bits, e.bits);
            chk("z_seq",     zv, e.zm);
            chk("latency",   ncyc, 9);
            chk("busy_done", busy, 1);
            chk("bit_out_done", bit_out, 0);
            $display("txn id=%0d word=%02h match_cnt=%0d z=%09b", done_id, bits, match_cnt, zv);
          end
          bits = '0; zv = '0; ncyc = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ack0, ack1, busy, bit_out, z, done, done_id, match_cnt}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single word, two overlapping-capable matches.
    do_word(0, 8'h36, 4'd2, 9'b000010010);
    // Match completed by the final bit: z visible in DONE.
    do_word(1, 8'h03, 4'd1, 9'b000000001);

    // Both held: alternation starting with 0 (last served was 1).
    done_cyc.delete();
    push(0, 8'hFF, 4'd0, 9'd0);
    push(1, 8'h00, 4'd0, 9'd0);
    push(0, 8'hFF, 4'd0, 9'd0);
    push(1, 8'h00, 4'd0, 9'd0);
    req0 = 1'b1; data0 = 8'hFF; req1 = 1'b1; data1 = 8'h00;
    begin
      int n = 0;
      for (int i = 0; i < 80 && n < 4; i++) begin
        @(negedge clk);
        if (ack0 || ack1) n++;
      end
      if (n < 4) chk("alt_timeout", n, 4);
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
    end
    if (done_cyc.size() >= 4)
      for (int i = 0; i < 3; i++) chk("grant_spacing", done_cyc[i+1] - done_cyc[i], 10);
    else
      chk("alt_done_count", done_cyc.size(), 4);

    // History must not carry across words (01 then 80 would form 011).
    do_word(0, 8'h01, 4'd0, 9'd0);
    do_word(0, 8'h80, 4'd0, 9'd0);

    // Reset in the 4th SHIFT cycle abandons the word; held req0 is re-granted.
    push(0, 8'h36, 4'd2, 9'b000010010);
    req0 = 1'b1; data0 = 8'h36;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_bit_out", bit_out, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_outputs", {ack0, ack1, busy, bit_out, z, done, done_id, match_cnt}, 0);
    @(posedge clk); #2 rst = 1'b0;
    wait_ack(0);

    // Data changing mid-SHIFT is ignored.
    push(0, 8'h36, 4'd2, 9'b000010010);
    req0 = 1'b1; data0 = 8'h36;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 data0 = 8'hFF;
    wait_ack(0);

    repeat (15) @(negedge clk);
    chk("queue_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_det_arb.md
Name: serial_det_arb

Overview:
- Round-robin arbiter and sequencer that shares one bit-serial pattern detector between two word-wide requesters.
- A granted word is loaded, shifted MSB-first through a programmable detector, and its overlapping pattern matches are counted.
- Completion is reported to the owning requester by a one-cycle ack, with the match count.
- Sits between parallel producers and the serial sequence-detection logic of the design.

Parameters:
DW, 8, data word width (bits serialized per grant)
PLEN, 3, pattern length in bits (2..DW)
PAT, 3'b011, pattern to detect; first-shifted bit is PAT[PLEN-1]
CW, 4, match counter width; must satisfy 2^CW > DW

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  asynchronous, active-high reset
req0  in  1  requester 0 request; held high with data0 stable until ack0
data0  in  DW  requester 0 word
req1  in  1  requester 1 request; held high with data1 stable until ack1
data1  in  DW  requester 1 word
ack0  out  1  one-cycle completion pulse to requester 0
ack1  out  1  one-cycle completion pulse to requester 1
busy  out  1  high in SHIFT and DONE
bit_out  out  1  bit consumed by the detector this cycle (valid in SHIFT, else 0)
z  out  1  registered match flag, high one cycle after the completing bit
done  out  1  one-cycle pulse, coincident with ack
done_id  out  1  requester served by the current or last transaction
match_cnt  out  CW  matches in the current or last word

Behaviour:
- Reset: state=IDLE, last_id=1 (requester 0 wins the first tie).
- Reset also clears the shift register, history, fill and bit counters, and match_cnt.
- Reset drives all outputs to 0.
- Reset is honoured in any state; an in-flight transaction is abandoned with no ack.
- IDLE:
  - No request: remain in IDLE.
  - Only one req high: grant it.
  - Both high: grant !last_id.
  - On grant edge: load the shift register from the granted data, set cur_id=done_id=granted id, clear match_cnt, history, fill count and bit count; go to SHIFT.
- SHIFT, exactly DW cycles:
  - bit_out = shreg[DW-1].
  - Each edge: shreg shifts left by 1, history <= {history[PLEN-2:0], bit_out}, fill count saturates at PLEN.
  - Match when fill count >= PLEN-1 (before the edge) and {history[PLEN-2:0], bit_out} == PAT.
  - On match, match_cnt increments and z is set for the next cycle; otherwise z=0.
  - Overlapping matches count.
  - After the DW-th bit, go to DONE.
- DONE, 1 cycle:
  - ack[cur_id]=1, done=1.
  - z may be high here if the last bit completed a match.
  - Edge: last_id <= cur_id; go to IDLE.
- Fixed latency: grant edge to done = DW+1 cycles.
  - Minimum spacing between two grants is DW+2 cycles (DONE is followed by one IDLE cycle).
- Detector history never carries across words; each word starts with empty history.
- Requesters sample ack synchronously and drop req on the edge where they see ack.
  - A req still high in the IDLE cycle after DONE is treated as a new request.
- req/data changes during SHIFT or DONE are ignored.
  - The word is captured at grant; the non-granted request waits.
- match_cnt and done_id hold after DONE until the next grant edge.
- No overflow is possible: the maximum count DW-PLEN+1 fits in CW bits.

Test Plan:
- Reset then req0=1, data0=8'h36 (bits 0,0,1,1,0,1,1,0) -> bit_out follows that sequence over 8 SHIFT cycles; z high after the 4th and 7th bits; ack0/done pulse; done_id=0; match_cnt=2.
- req1 only, data1=8'h03 -> single match on the final bit; z high in the DONE cycle; ack1 pulse; done_id=1; match_cnt=1.
- Cross-word isolation: data0=8'h01, then data0=8'h80 -> both words report match_cnt=0; no match across the word boundary.
- req0 and req1 both held high continuously, data0=8'hFF, data1=8'h00 -> grants alternate 0,1,0,1 starting with 0; each word reports match_cnt=0; grants spaced 10 cycles apart.
- Assert rst for 1 cycle at the 4th SHIFT cycle of data0=8'h36 -> all outputs 0 immediately; no ack0; state IDLE; after release, the still-high req0 is re-granted and completes with match_cnt=2.
- Change data0 from 8'h36 to 8'hFF mid-SHIFT -> match_cnt=2 (captured word used); ack0 pulses once.
